// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Groups the hazard event inputs and the pipeline-register control outputs
//   of pipeline_hazard_ctrl.
//   master : pipeline side. It drives the events and receives the controls.
//   slave  : sequencer side (pipeline_hazard_ctrl).
//   Events   : ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_Jump,
//              EX_BranchTaken, Mem_Busy, IRQ, IRQ_Mask
//   Controls : PC_Write, PC_Sel, IF_ID_Write, IF_Flush, ID_EX_Bubble,
//              Pipe_Hold, ID_IRQ, IRQ_Ack
//   HAZARD_PERF_CNT_EN adds the Stall_Cnt and Flush_Cnt counters.
interface pipeline_hazard_ctrl_if;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Rt;
  logic [4:0] IF_ID_Rs;
  logic [4:0] IF_ID_Rt;
  logic       ID_UsesRt;
  logic       ID_Jump;
  logic       EX_BranchTaken;
  logic       Mem_Busy;
  logic       IRQ;
  logic       IRQ_Mask;

  logic       PC_Write;
  logic [1:0] PC_Sel;
  logic       IF_ID_Write;
  logic       IF_Flush;
  logic       ID_EX_Bubble;
  logic       Pipe_Hold;
  logic       ID_IRQ;
  logic       IRQ_Ack;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] Stall_Cnt;
  logic [15:0] Flush_Cnt;
`endif

  modport master (
    output ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_Jump,
           EX_BranchTaken, Mem_Busy, IRQ, IRQ_Mask,
`ifdef HAZARD_PERF_CNT_EN
    input  Stall_Cnt, Flush_Cnt,
`endif
    input  PC_Write, PC_Sel, IF_ID_Write, IF_Flush, ID_EX_Bubble, Pipe_Hold,
           ID_IRQ, IRQ_Ack
  );

  modport slave (
    input  ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_Jump,
           EX_BranchTaken, Mem_Busy, IRQ, IRQ_Mask,
`ifdef HAZARD_PERF_CNT_EN
    output Stall_Cnt, Flush_Cnt,
`endif
    output PC_Write, PC_Sel, IF_ID_Write, IF_Flush, ID_EX_Bubble, Pipe_Hold,
           ID_IRQ, IRQ_Ack
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Every cycle it
//   decides whether the PC, IF/ID and the downstream registers advance, hold
//   or flush. It also selects the PC source.
//   Ports:
//     sysclk : pipeline clock. State updates on the rising edge.
//     reset  : asynchronous, active-low. While it is low the outputs are idle.
//     hz     : pipeline_hazard_ctrl_if.slave, which carries the events in and
//              the controls out.
//   Parameter IRQ_BLOCK_CYCLES (1..15): the number of cycles after an
//   interrupt entry during which a new interrupt is not accepted.
//   Optional feature macro: HAZARD_PERF_CNT_EN. It adds the saturating
//   16-bit Stall_Cnt and Flush_Cnt counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned IRQ_BLOCK_CYCLES = 3
) (
  input  logic                   sysclk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, IRQ_BLOCK} state_e;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_EXC    = 2'd3;
  localparam logic [3:0] BLK_LOAD  = 4'(IRQ_BLOCK_CYCLES);

  state_e     state_q, state_d;
  logic       irq_pend_q, irq_pend_d;
  logic [3:0] blk_cnt_q, blk_cnt_d;

  logic       load_use;
  logic       irq_req;
  logic       irq_accept;

  logic       pc_write, if_id_write, if_flush, bubble, hold, id_irq, irq_ack;
  logic [1:0] pc_sel;

  assign load_use = hz.ID_EX_MemRead && (hz.ID_EX_Rt != '0) &&
                    ((hz.ID_EX_Rt == hz.IF_ID_Rs) ||
                     (hz.ID_UsesRt && (hz.ID_EX_Rt == hz.IF_ID_Rt)));

  assign irq_req = (irq_pend_q || hz.IRQ) && !hz.IRQ_Mask;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      irq_pend_q <= 1'b0;
      blk_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    blk_cnt_d   = blk_cnt_q;
    irq_accept  = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    pc_sel      = PC_SEQ;
    if_flush    = 1'b0;
    bubble      = 1'b0;
    hold        = 1'b0;
    id_irq      = 1'b0;
    irq_ack     = 1'b0;

    case (state_q)
      MEM_WAIT: begin
        if (hz.Mem_Busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          hold        = 1'b1;
        end else begin
          // blk_cnt is only nonzero while a block is in progress. It is 0 in
          // RUN because the block exits on the 1->0 decrement. For that
          // reason it also records which state the wait was entered from.
          state_d = (blk_cnt_q != '0) ? IRQ_BLOCK : RUN;
        end
      end

      default: begin // RUN, IRQ_BLOCK
        if (hz.Mem_Busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          hold        = 1'b1;
          state_d     = MEM_WAIT;
        end else begin
          if (state_q == IRQ_BLOCK) begin
            blk_cnt_d = blk_cnt_q - 4'd1;
            if (blk_cnt_q <= 4'd1) state_d = RUN;
          end
          if (hz.EX_BranchTaken) begin
            pc_sel   = PC_BRANCH;
            if_flush = 1'b1;
            bubble   = 1'b1;
          end else if ((state_q == RUN) && irq_req) begin
            pc_sel     = PC_EXC;
            if_flush   = 1'b1;
            id_irq     = 1'b1;
            irq_ack    = 1'b1;
            irq_accept = 1'b1;
            blk_cnt_d  = BLK_LOAD;
            state_d    = IRQ_BLOCK;
          end else if (hz.ID_Jump) begin
            pc_sel   = PC_JUMP;
            if_flush = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble      = 1'b1;
          end
        end
      end
    endcase

    irq_pend_d = irq_accept ? 1'b0 : (irq_pend_q || hz.IRQ);
  end

  // While reset is low the outputs are forced to their idle values, even
  // though the state registers are already cleared asynchronously.
  always_comb begin
    hz.PC_Write     = 1'b1;
    hz.IF_ID_Write  = 1'b1;
    hz.PC_Sel       = PC_SEQ;
    hz.IF_Flush     = 1'b0;
    hz.ID_EX_Bubble = 1'b0;
    hz.Pipe_Hold    = 1'b0;
    hz.ID_IRQ       = 1'b0;
    hz.IRQ_Ack      = 1'b0;
    if (reset) begin
      hz.PC_Write     = pc_write;
      hz.IF_ID_Write  = if_id_write;
      hz.PC_Sel       = pc_sel;
      hz.IF_Flush     = if_flush;
      hz.ID_EX_Bubble = bubble;
      hz.Pipe_Hold    = hold;
      hz.ID_IRQ       = id_irq;
      hz.IRQ_Ack      = irq_ack;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hz.PC_Write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (hz.IF_Flush  && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.Stall_Cnt = stall_cnt_q;
  assign hz.Flush_Cnt = flush_cnt_q;
`endif

endmodule
